// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the host-side FFT stream adapter.
package fft_pkg;

    localparam int FFT_DW    = 16;
    localparam int FFT_BEATS = 8;
    localparam int FFT_STALL = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_FEED    = 3'd2,
        S_WAIT    = 3'd3,
        S_COLLECT = 3'd4,
        S_COOL    = 3'd5
    } fft_state_t;

endpackage

// File: rtl/fft_obuf.sv
// Synchronous FIFO holding captured result pairs; reads as zero when empty.
module fft_obuf #(
    parameter int W     = 65,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] free_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push_i && (cnt_q != CW'(DEPTH));
    assign do_pop_s  = pop_i && (cnt_q != '0);

    // Pointer and occupancy tracking
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push_s) begin
                wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array
    always_ff @(posedge CLK) begin
        if (do_push_s) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    assign rdata_o = (cnt_q == '0) ? '0 : mem_q[rd_q];
    assign count_o = cnt_q;
    assign free_o  = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/fft_host_if.sv
// Buffers one input frame, feeds it to the FFT core after START, and captures
// the core's unstallable DONE-window results into an output FIFO.
module fft_host_if
    import fft_pkg::*;
#(
    parameter int DW         = FFT_DW,
    parameter int OUT_LAT    = 1,
    parameter int OBUF_DEPTH = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [2*DW-1:0] s_data0,
    input  logic [2*DW-1:0] s_data1,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [2*DW-1:0] m_data0,
    output logic [2*DW-1:0] m_data1,
    output logic          m_last,
    output logic          core_start,
    output logic [2*DW-1:0] core_din0,
    output logic [2*DW-1:0] core_din1,
    input  logic          core_done,
    input  logic [2*DW-1:0] core_dout0,
    input  logic [2*DW-1:0] core_dout1,
    output logic          frame_err,
    output logic          busy
);

    localparam int PW = 2 * DW;
    localparam int OW = 4 * DW + 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);

    fft_state_t        state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [1:0]        cool_q, cool_d;
    logic [3:0]        icnt_q;
    logic [2:0]        ibeat_q;
    logic [2:0]        pcnt_q;
    logic              frame_err_q;
    logic [OUT_LAT-1:0] done_pipe_q;
    logic [PW-1:0]     ibuf0_q [FFT_BEATS];
    logic [PW-1:0]     ibuf1_q [FFT_BEATS];

    logic              in_acc_s;
    logic              clr_icnt_s;
    logic              push_s;
    logic              pop_s;
    logic [OW-1:0]     ob_wdata_s;
    logic [OW-1:0]     ob_rdata_s;
    logic [CW-1:0]     ob_count_s;
    logic [CW-1:0]     ob_free_s;

    assign s_ready  = (icnt_q < 4'd8) && (state_q != S_FEED);
    assign in_acc_s = s_valid && s_ready;

    // Input beat counting and sticky framing check
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            icnt_q      <= 4'd0;
            ibeat_q     <= 3'd0;
            frame_err_q <= 1'b0;
        end else begin
            if (clr_icnt_s) begin
                icnt_q <= 4'd0;
            end else if (in_acc_s) begin
                icnt_q <= icnt_q + 4'd1;
            end
            if (in_acc_s) begin
                ibeat_q <= ibeat_q + 3'd1;
                if (s_last != (ibeat_q == 3'd7)) begin
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    // Input pair RAM; contents are only meaningful while icnt says so
    always_ff @(posedge CLK) begin
        if (in_acc_s) begin
            ibuf0_q[ibeat_q] <= s_data0;
            ibuf1_q[ibeat_q] <= s_data1;
        end
    end

    // FSM, feed/cool counters, DONE delay pipe and push-beat index
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            fcnt_q      <= 3'd0;
            cool_q      <= 2'd0;
            pcnt_q      <= 3'd0;
            done_pipe_q <= '0;
        end else begin
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            cool_q         <= cool_d;
            done_pipe_q[0] <= core_done;
            for (int i = 1; i < OUT_LAT; i++) begin
                done_pipe_q[i] <= done_pipe_q[i-1];
            end
            if (push_s) begin
                pcnt_q <= pcnt_q + 3'd1;
            end
        end
    end

    assign push_s = (state_q == S_COLLECT) && done_pipe_q[OUT_LAT-1];

    // Next-state logic; START is gated on room for a whole result frame
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        cool_d     = cool_q;
        clr_icnt_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((icnt_q == 4'd8) && (ob_free_s >= CW'(FFT_BEATS))) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_FEED;
                fcnt_d  = 3'd0;
            end
            S_FEED: begin
                if (fcnt_q == 3'd7) begin
                    state_d    = S_WAIT;
                    fcnt_d     = 3'd0;
                    clr_icnt_s = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d = S_COLLECT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_COLLECT: begin
                if (push_s && (pcnt_q == 3'd7)) begin
                    state_d = S_COOL;
                    cool_d  = 2'd0;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_COOL: begin
                if (cool_q == 2'(FFT_STALL - 1)) begin
                    state_d = S_IDLE;
                    cool_d  = 2'd0;
                end else begin
                    cool_d = cool_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ob_wdata_s = {(pcnt_q == 3'd7), core_dout0, core_dout1};
    assign pop_s      = m_valid && m_ready;

    fft_obuf #(
        .W     (OW),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .push_i  (push_s),
        .wdata_i (ob_wdata_s),
        .pop_i   (pop_s),
        .rdata_o (ob_rdata_s),
        .count_o (ob_count_s),
        .free_o  (ob_free_s)
    );

    assign m_valid    = (ob_count_s != '0);
    assign m_last     = ob_rdata_s[OW-1];
    assign m_data0    = ob_rdata_s[4*DW-1:2*DW];
    assign m_data1    = ob_rdata_s[2*DW-1:0];
    assign core_start = (state_q == S_START);
    assign core_din0  = (state_q == S_FEED) ? ibuf0_q[fcnt_q] : '0;
    assign core_din1  = (state_q == S_FEED) ? ibuf1_q[fcnt_q] : '0;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fft_host_if.sv
// Randomized bench for fft_host_if with a behavioural FFT-core responder
// (DONE 20 cycles after feed, dout = din + 1) and a frame-level reference queue.
module tb_fft_host_if;

    localparam int COMPUTE = 20;
    localparam int BOUND   = 2000;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        s_valid, s_ready, s_last;
    logic [31:0] s_data0, s_data1;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data0, m_data1;
    logic        core_start, core_done;
    logic [31:0] core_din0, core_din1, core_dout0, core_dout1;
    logic        frame_err, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rmode = 2;

    logic [64:0] exp_q[$];
    logic [64:0] out_log[$];
    logic [63:0] din_exp[$];
    logic [63:0] din_log[$];
    int          start_log[$];
    int          rise_log[$];
    int          oc_idx = 0;
    int          de_idx = 0;
    int          dl_idx = 0;

    fft_host_if dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data0    (s_data0),
        .s_data1    (s_data1),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data0    (m_data0),
        .m_data1    (m_data1),
        .m_last     (m_last),
        .core_start (core_start),
        .core_din0  (core_din0),
        .core_din1  (core_din1),
        .core_done  (core_done),
        .core_dout0 (core_dout0),
        .core_dout1 (core_dout1),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural FFT core: capture 8 pairs after START, compute, then emit
    int          rs_ph, rs_k, rs_cnt;
    logic [31:0] rs_d0 [8];
    logic [31:0] rs_d1 [8];
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rs_ph <= 0; rs_k <= 0; rs_cnt <= 0;
            core_done <= 1'b0; core_dout0 <= 32'd0; core_dout1 <= 32'd0;
        end else begin
            case (rs_ph)
                0: if (core_start) begin
                    rs_ph <= 1; rs_k <= 0; start_log.push_back(cyc);
                end
                1: begin
                    rs_d0[rs_k] <= core_din0; rs_d1[rs_k] <= core_din1;
                    din_log.push_back({core_din0, core_din1});
                    if (rs_k == 7) begin rs_ph <= 2; rs_cnt <= 0; end
                    else rs_k <= rs_k + 1;
                end
                2: if (rs_cnt == COMPUTE - 1) begin
                    rs_ph <= 3; rs_k <= 0; core_done <= 1'b1;
                    rise_log.push_back(cyc + 1);
                end else rs_cnt <= rs_cnt + 1;
                3: begin
                    if (rs_k < 8) begin
                        core_dout0 <= rs_d0[rs_k] + 32'd1;
                        core_dout1 <= rs_d1[rs_k] + 32'd1;
                        if (rs_k == 7) core_done <= 1'b0;
                        rs_k <= rs_k + 1;
                    end else begin
                        core_dout0 <= 32'd0; core_dout1 <= 32'd0; rs_ph <= 0;
                    end
                end
                default: rs_ph <= 0;
            endcase
        end
    end

    // Downstream: drive m_ready per mode and log accepted beats
    initial begin
        m_ready = 1'b0;
        forever begin
            @(negedge CLK);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
            #1;
            if (m_valid && m_ready) out_log.push_back({m_last, m_data0, m_data1});
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] d0, input logic [31:0] d1, input logic last);
        int tmo = 0;
        s_valid = 1'b1; s_data0 = d0; s_data1 = d1; s_last = last;
        while (!s_ready && tmo < BOUND) begin @(negedge CLK); tmo++; end
        if (tmo >= BOUND) check_eq("s_ready_timeout", 64'(s_ready), 64'd1);
        @(negedge CLK);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // det: re=k, im=-k on both lanes; keep: frame is expected to complete
    task automatic send_frame(input int last_at, input bit keep, input bit det, input bit gaps);
        logic [31:0] d0, d1;
        for (int k = 0; k < 8; k++) begin
            if (det) begin
                d0 = {16'(k), 16'(-k)}; d1 = d0;
            end else begin
                d0 = $urandom; d1 = $urandom;
            end
            if (keep) begin
                exp_q.push_back({(k == 7), d0 + 32'd1, d1 + 32'd1});
                din_exp.push_back({d0, d1});
            end
            push_beat(d0, d1, (k == last_at));
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
    endtask

    task automatic wait_outs(input int n);
        int tmo = 0;
        while (out_log.size() < n && tmo < BOUND) begin @(negedge CLK); tmo++; end
        if (tmo >= BOUND) check_eq("out_timeout", 64'(out_log.size()), 64'(n));
    endtask

    task automatic wait_starts(input int n);
        int tmo = 0;
        while (start_log.size() < n && tmo < BOUND) begin @(negedge CLK); tmo++; end
        if (tmo >= BOUND) check_eq("start_timeout", 64'(start_log.size()), 64'(n));
    endtask

    task automatic wait_idle();
        int tmo = 0;
        while (busy && tmo < BOUND) begin @(negedge CLK); tmo++; end
        if (tmo >= BOUND) check_eq("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic compare_all(input string tag);
        wait_outs(exp_q.size());
        while (oc_idx < exp_q.size() && oc_idx < out_log.size()) begin
            check_eq({tag, "_data"}, out_log[oc_idx][63:0], exp_q[oc_idx][63:0]);
            check_eq({tag, "_last"}, 64'(out_log[oc_idx][64]), 64'(exp_q[oc_idx][64]));
            oc_idx++;
        end
        while (de_idx < din_exp.size()) begin
            if (dl_idx < din_log.size()) check_eq({tag, "_core_din"}, din_log[dl_idx], din_exp[de_idx]);
            else check_eq({tag, "_core_din_missing"}, 64'(din_log.size()), 64'(dl_idx + 1));
            de_idx++; dl_idx++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_s_ready"}, 64'(s_ready), 64'd1);
        check_eq({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check_eq({tag, "_m_last"}, 64'(m_last), 64'd0);
        check_eq({tag, "_m_data"}, {m_data0, m_data1}, 64'd0);
        check_eq({tag, "_core_start"}, 64'(core_start), 64'd0);
        check_eq({tag, "_core_din"}, {core_din0, core_din1}, 64'd0);
        check_eq({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int s0, r0, n0;
        RSTn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data0 = 32'd0; s_data1 = 32'd0;
        repeat (3) @(negedge CLK);
        #1 check_reset_vals("rst");
        @(negedge CLK);
        RSTn = 1'b1;
        rmode = 0;
        @(negedge CLK);

        // Single deterministic frame
        send_frame(7, 1'b1, 1'b1, 1'b0);
        compare_all("single");
        check_eq("single_frame_err", 64'(frame_err), 64'd0);

        // Back-pressure through the whole DONE window
        rmode = 2;
        s0 = start_log.size(); n0 = out_log.size();
        send_frame(7, 1'b1, 1'b0, 1'b1);
        wait_starts(s0 + 1);
        wait_idle();
        check_eq("bp_m_valid_held", 64'(m_valid), 64'd1);
        check_eq("bp_no_pops", 64'(out_log.size()), 64'(n0));
        rmode = 1;
        compare_all("bp");
        rmode = 0;

        // Overlap: second frame fills while the first is in flight
        s0 = start_log.size(); r0 = rise_log.size();
        send_frame(7, 1'b1, 1'b0, 1'b0);
        send_frame(7, 1'b1, 1'b0, 1'b0);
        check_eq("ovl_fill_before_done", 64'(rise_log.size()), 64'(r0));
        check_eq("ovl_busy", 64'(busy), 64'd1);
        wait_starts(s0 + 2);
        if (start_log.size() >= s0 + 2 && rise_log.size() > r0)
            check_eq("ovl_start_spacing", 64'(start_log[s0+1] >= rise_log[r0] + 8 + 3), 64'd1);
        else
            check_eq("ovl_logs_missing", 64'(rise_log.size()), 64'(r0 + 1));
        compare_all("ovl");

        // Output-full gating: third START withheld until 8 slots free
        rmode = 2;
        s0 = start_log.size();
        send_frame(7, 1'b1, 1'b0, 1'b1);
        send_frame(7, 1'b1, 1'b0, 1'b1);
        send_frame(7, 1'b1, 1'b0, 1'b1);
        wait_starts(s0 + 2);
        wait_idle();
        repeat (40) @(negedge CLK);
        check_eq("full_start_withheld", 64'(start_log.size()), 64'(s0 + 2));
        check_eq("full_busy", 64'(busy), 64'd0);
        check_eq("full_s_ready", 64'(s_ready), 64'd0);
        rmode = 0;
        compare_all("full");
        check_eq("full_third_start", 64'(start_log.size()), 64'(s0 + 3));

        // Framing error: s_last on beat 3
        send_frame(3, 1'b1, 1'b0, 1'b1);
        check_eq("ferr_set", 64'(frame_err), 64'd1);
        compare_all("ferr");
        check_eq("ferr_sticky", 64'(frame_err), 64'd1);

        // Reset during feed beat 4
        s0 = start_log.size();
        send_frame(7, 1'b0, 1'b0, 1'b0);
        wait_starts(s0 + 1);
        repeat (4) @(negedge CLK);
        RSTn = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        dl_idx = din_log.size();
        @(negedge CLK);
        send_frame(7, 1'b1, 1'b0, 1'b1);
        compare_all("postrst");
        check_eq("postrst_frame_err", 64'(frame_err), 64'd0);
        repeat (20) @(negedge CLK);
        check_eq("postrst_extra_out", 64'(out_log.size()), 64'(exp_q.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
